// File: rtl/spi_wb_master_ctrl.sv
// Bus-clock sequencer: turns a synchronised SPI start strobe into one classic
// Wishbone cycle, with timeout/error handling, overrun detection and status.
module spi_wb_master_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_PATTERN  = 32'hDEAD_BEEF
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic                  spi_start,
    input  logic                  spi_wrn,
    input  logic [3:0]            spi_select,
    input  logic [18:0]           spi_address,
    input  logic [31:0]           spi_data,
    output logic [31:0]           rd_data,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  busy,
    output logic                  err_sticky,
    output logic                  overrun_sticky,
    input  logic                  err_clear,
    output logic [15:0]           xfer_count
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        BUS,
        DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    logic                  sync1_q, sync2_q, sync3_q;
    logic                  start_pulse;
    logic [15:0]           tmo_q;
    logic [31:0]           rd_q;
    logic                  cyc_q, stb_q, we_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;
    logic                  busy_q, err_q, ovr_q;
    logic [15:0]           xfer_q;

    assign start_pulse = sync2_q & ~sync3_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tmo_q   <= '0;
            rd_q    <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            xfer_q  <= '0;
        end else begin
            sync1_q <= spi_start;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;

            // Clear first so a coincident set event later in this block wins.
            if (err_clear) begin
                err_q <= 1'b0;
                ovr_q <= 1'b0;
            end
            if (start_pulse && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        busy_q  <= 1'b1;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    we_q    <= spi_wrn;
                    sel_q   <= spi_select;
                    adr_q   <= ADDR_WIDTH'(spi_address);
                    dat_q   <= spi_wrn ? spi_data : '0;
                    tmo_q   <= '0;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    state_q <= BUS;
                end
                BUS: begin
                    if (wb_ack_i || wb_err_i || tmo_q == TO_LAST) begin
                        if (wb_ack_i) begin
                            if (!we_q) rd_q <= wb_dat_i;
                        end else begin
                            err_q <= 1'b1;
                            if (!we_q) rd_q <= ERROR_PATTERN;
                        end
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                DONE: begin
                    xfer_q  <= xfer_q + 16'd1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data        = rd_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign wb_we_o        = we_q;
    assign wb_sel_o       = sel_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign busy           = busy_q;
    assign err_sticky     = err_q;
    assign overrun_sticky = ovr_q;
    assign xfer_count     = xfer_q;

endmodule

// File: tb/tb_spi_wb_master_ctrl.sv
// Scoreboard bench: stimulus pushes expected Wishbone cycles, a negedge monitor
// compares request fields at cyc rise and results when cyc falls.
module tb_spi_wb_master_ctrl;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        spi_start, spi_wrn;
    logic [3:0]  spi_select;
    logic [18:0] spi_address;
    logic [31:0] spi_data, rd_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i, busy, err_sticky, overrun_sticky, err_clear;
    logic [15:0] xfer_count;

    spi_wb_master_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .ERROR_PATTERN(32'hDEAD_BEEF)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .spi_start(spi_start), .spi_wrn(spi_wrn),
        .spi_select(spi_select), .spi_address(spi_address), .spi_data(spi_data),
        .rd_data(rd_data), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .busy(busy), .err_sticky(err_sticky),
        .overrun_sticky(overrun_sticky), .err_clear(err_clear), .xfer_count(xfer_count)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr, dat, rd;
        logic        err;
        logic [15:0] xfer;
        int unsigned len;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0, n_bad = 0;
    bit          skip_mon = 1'b0;

    localparam int RESP_ACK = 0, RESP_ERR = 1, RESP_NONE = 2, RESP_BOTH = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: request fields at cyc rise, results on the DONE cycle, count one cycle later.
    logic        prev_cyc = 1'b0, pend = 1'b0;
    int unsigned len = 0;
    logic [15:0] exp_x;
    always @(negedge wb_clk) begin
        if (!wb_rst_n) begin
            prev_cyc = 1'b0;
            pend     = 1'b0;
            len      = 0;
        end else begin
            if (pend) begin
                chk("xfer_count", 32'(xfer_count), 32'(exp_x));
                pend = 1'b0;
            end
            if (wb_cyc_o && !prev_cyc) begin
                len = 1;
                if (sb.size() == 0) begin
                    if (!skip_mon) chk("unexpected_cycle", 32'd1, 32'd0);
                end else begin
                    chk("stb", 32'(wb_stb_o), 32'd1);
                    chk("we", 32'(wb_we_o), 32'(sb[0].we));
                    chk("sel", 32'(wb_sel_o), 32'(sb[0].sel));
                    chk("adr", wb_adr_o, sb[0].adr);
                    chk("dat_o", wb_dat_o, sb[0].dat);
                end
            end else if (wb_cyc_o) begin
                len++;
            end
            if (!wb_cyc_o && prev_cyc && sb.size() > 0 && !skip_mon) begin
                exp_t e;
                e = sb.pop_front();
                chk("cyc_len", len, e.len);
                chk("rd_data", rd_data, e.rd);
                chk("err_sticky", 32'(err_sticky), 32'(e.err));
                chk("busy_done", 32'(busy), 32'd1);
                exp_x = e.xfer;
                pend  = 1'b1;
            end
            prev_cyc = wb_cyc_o;
        end
    end

    task automatic do_cmd(input logic wrn, input logic [3:0] sel, input logic [18:0] addr,
                          input logic [31:0] data, input int resp, input int delay,
                          input logic [31:0] slv_dat, input bit ovr, input bit push,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [15:0] exp_xfer, input int unsigned exp_len);
        exp_t e;
        int   k;
        e.we = wrn; e.sel = sel; e.adr = {13'd0, addr}; e.dat = wrn ? data : 32'd0;
        e.rd = exp_rd; e.err = exp_err; e.xfer = exp_xfer; e.len = exp_len;
        if (push) sb.push_back(e);
        spi_wrn = wrn; spi_select = sel; spi_address = addr; spi_data = data;
        spi_start = 1'b1;
        k = 0;
        while (!wb_cyc_o && k < 20) begin
            @(negedge wb_clk);
            k++;
        end
        chk("start_latency", 32'(k), 32'd4);
        if (!wb_cyc_o) return;
        for (int i = 0; i < delay; i++) begin
            if (ovr && i == 0) spi_start = 1'b0;
            if (ovr && i == 5) spi_start = 1'b1;
            @(negedge wb_clk);
        end
        if (resp != RESP_NONE) begin
            wb_dat_i = slv_dat;
            wb_ack_i = (resp == RESP_ACK || resp == RESP_BOTH);
            wb_err_i = (resp == RESP_ERR || resp == RESP_BOTH);
            @(negedge wb_clk);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        end
        k = 0;
        while (busy && k < 40) begin
            @(negedge wb_clk);
            k++;
        end
        chk("busy_release", 32'(busy), 32'd0);
        spi_start = 1'b0;
        repeat (4) @(negedge wb_clk);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge wb_clk);
        err_clear = 1'b0;
        @(negedge wb_clk);
    endtask

    initial begin
        wb_rst_n = 1'b0; spi_start = 1'b0; spi_wrn = 1'b0; spi_select = '0;
        spi_address = '0; spi_data = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
        wb_err_i = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge wb_clk);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk);

        // Word write, ack after 3 wait cycles.
        do_cmd(1'b1, 4'hF, 19'h0_1234, 32'hCAFE_F00D, RESP_ACK, 3, 32'h0, 1'b0, 1'b1,
               32'h0, 1'b0, 16'd1, 4);
        // Byte read, immediate ack; write data must not leak onto dat_o.
        do_cmd(1'b0, 4'h1, 19'h7_FFFF, 32'h1234_5678, RESP_ACK, 0, 32'h0000_00A5, 1'b0, 1'b1,
               32'h0000_00A5, 1'b0, 16'd2, 1);
        // Read timeout after 16 cycles.
        do_cmd(1'b0, 4'hF, 19'h0_0100, 32'h0, RESP_NONE, 0, 32'h0, 1'b0, 1'b1,
               32'hDEAD_BEEF, 1'b1, 16'd3, 16);
        pulse_clear();
        chk("err_cleared_tmo", 32'(err_sticky), 32'd0);
        // Write bus error after 2 wait cycles; rd_data keeps the error pattern.
        do_cmd(1'b1, 4'h3, 19'h0_0040, 32'h1111_2222, RESP_ERR, 2, 32'h0, 1'b0, 1'b1,
               32'hDEAD_BEEF, 1'b1, 16'd4, 3);
        pulse_clear();
        chk("err_cleared_err", 32'(err_sticky), 32'd0);
        // Ack and err together: ack wins.
        do_cmd(1'b0, 4'hC, 19'h4_0000, 32'h0, RESP_BOTH, 1, 32'h5A5A_0001, 1'b0, 1'b1,
               32'h5A5A_0001, 1'b0, 16'd5, 2);
        chk("ovr_idle", 32'(overrun_sticky), 32'd0);
        // Second start edge while waiting on ack.
        do_cmd(1'b0, 4'hF, 19'h0_0200, 32'h0, RESP_ACK, 12, 32'h0BAD_F00D, 1'b1, 1'b1,
               32'h0BAD_F00D, 1'b0, 16'd6, 13);
        chk("ovr_set", 32'(overrun_sticky), 32'd1);
        pulse_clear();
        chk("ovr_cleared", 32'(overrun_sticky), 32'd0);

        // Reset mid-cycle.
        skip_mon = 1'b1;
        spi_wrn = 1'b0; spi_select = 4'hF; spi_address = 19'h0_0300; spi_data = '0;
        spi_start = 1'b1;
        for (int i = 0; i < 20 && !wb_cyc_o; i++) @(negedge wb_clk);
        chk("rst_mid_cyc_seen", 32'(wb_cyc_o), 32'd1);
        @(negedge wb_clk);
        #2 wb_rst_n = 1'b0;
        spi_start = 1'b0;
        #1;
        chk("async_cyc", 32'(wb_cyc_o), 32'd0);
        chk("async_stb", 32'(wb_stb_o), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_xfer", 32'(xfer_count), 32'd0);
        repeat (2) @(negedge wb_clk);
        #2 wb_rst_n = 1'b1;
        repeat (4) @(negedge wb_clk);
        skip_mon = 1'b0;

        do_cmd(1'b1, 4'hF, 19'h0_0008, 32'hA5A5_A5A5, RESP_ACK, 0, 32'h0, 1'b0, 1'b1,
               32'h0, 1'b0, 16'd1, 1);
        repeat (4) @(negedge wb_clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
